cb_stream_stuffer: RTL and testbench

- Output stage placed directly downstream of the Cb DCT/quantiser/Huffman chain.
- Accepts the 32-bit Huffman words as they are strobed out, buffers them in a small FIFO, and serialises them MSB byte first.
- Inserts a 0x00 byte after every 0xFF data byte (JPEG byte stuffing) and pads the final partial byte with 1s.
- Appends the EOI marker (0xFFD9) and repacks everything into 32-bit words on a valid/ready interface toward the file writer.

---
 rtl/cb_stream_stuffer.sv | 226 ++++++++++++++++++++++
 tb/tb_cb_stream_stuffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_stream_stuffer.sv
// Cb entropy-coded output stage: buffers Huffman words, serialises them MSB byte first
// with JPEG 0xFF->0xFF00 stuffing, 1-pads the tail byte, appends EOI and repacks to 32 bits.
module cb_stream_stuffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        eof,
  input  logic [31:0] eof_data,
  input  logic [4:0]  eof_bits,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_nbytes,
  output logic        out_last,
  output logic        overflow,
  output logic        busy
);

  typedef struct packed {
    logic        last;
    logic [4:0]  bits;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BYTE, S_STUFF, S_EOI_FF, S_EOI_D9, S_FLUSH
  } state_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  // ---------------- input FIFO + pending eof ----------------
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             pend_q;
  logic [31:0]      pend_data_q;
  logic [4:0]       pend_bits_q;
  logic             overflow_q;

  logic   push_req, push_ok, pop, fifo_full, fifo_avail;
  entry_t push_entry, head;
  logic [2:0] head_nbytes;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign push_req   = in_valid || pend_q;
  assign push_ok    = push_req && !fifo_full;
  assign fifo_avail = (cnt_q != '0) || push_ok;
  assign head       = mem_q[rd_ptr_q];
  assign head_nbytes = 3'(({1'b0, head.bits} + 6'd7) >> 3);

  always_comb begin
    push_entry = '0;
    if (in_valid) begin
      push_entry.data = in_data;
    end else begin
      push_entry.last = 1'b1;
      push_entry.bits = pend_bits_q;
      push_entry.data = pend_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push_req && fifo_full) overflow_q <= 1'b1;
    end
  end

  // eof waits here until a cycle without an in_valid push; that attempt consumes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_bits_q <= '0;
    end else if (eof) begin
      pend_q      <= 1'b1;
      pend_data_q <= eof_data;
      pend_bits_q <= eof_bits;
    end else if (!in_valid) begin
      pend_q      <= 1'b0;
    end
  end

  // ---------------- serialiser FSM ----------------
  state_t      state_q, state_d;
  logic [31:0] sr_q;
  logic [2:0]  rem_q, rem_dec;
  logic        last_q;

  logic        emit_req, emit_pack, flush_req;
  logic [7:0]  emit_byte;
  logic        out_free, word_done, emit_go, flush_go, out_load;

  logic [31:0] asm_data_q, asm_ins;
  logic [2:0]  asm_cnt_q;

  logic        out_valid_q, out_last_q;
  logic [31:0] out_data_q;
  logic [2:0]  out_nbytes_q;

  assign rem_dec = rem_q - 3'd1;

  function automatic state_t after_byte(input logic [2:0] rem, input logic last,
                                        input logic avail);
    if (rem != 3'd0) return S_BYTE;
    if (last)        return S_EOI_FF;
    return avail ? S_LOAD : S_IDLE;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (fifo_avail) state_d = S_LOAD;
      S_LOAD:   state_d = (head.last && head.bits == 5'd0) ? S_EOI_FF : S_BYTE;
      S_BYTE:   if (emit_go) state_d = (sr_q[31:24] == 8'hFF) ? S_STUFF
                                       : after_byte(rem_dec, last_q, fifo_avail);
      S_STUFF:  if (emit_go) state_d = after_byte(rem_q, last_q, fifo_avail);
      S_EOI_FF: if (emit_go) state_d = S_EOI_D9;
      S_EOI_D9: state_d = S_FLUSH;
      S_FLUSH:  if (flush_go) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // D9 is always appended without completing a word, so FLUSH carries it out with last=1
  always_comb begin
    pop       = 1'b0;
    emit_req  = 1'b0;
    emit_pack = 1'b1;
    emit_byte = 8'h00;
    flush_req = 1'b0;
    unique case (state_q)
      S_LOAD:   pop = 1'b1;
      S_BYTE:   begin emit_req = 1'b1; emit_byte = sr_q[31:24]; end
      S_STUFF:  emit_req = 1'b1;
      S_EOI_FF: begin emit_req = 1'b1; emit_byte = 8'hFF; end
      S_EOI_D9: begin emit_req = 1'b1; emit_pack = 1'b0; emit_byte = 8'hD9; end
      S_FLUSH:  flush_req = 1'b1;
      default:  ;
    endcase
  end

  assign out_free  = !out_valid_q || out_ready;
  assign word_done = emit_req && emit_pack && (asm_cnt_q == 3'd3);
  assign emit_go   = emit_req && (!word_done || out_free);
  assign flush_go  = flush_req && out_free;
  assign out_load  = (word_done && out_free) || flush_go;
  assign asm_ins   = asm_data_q | ({emit_byte, 24'h0} >> {asm_cnt_q[1:0], 3'b000});

  // tail padding: every bit past the valid ones is forced to 1; only head_nbytes are sent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
    end else if (pop) begin
      sr_q   <= head.last ? (head.data | (32'hFFFF_FFFF >> head.bits)) : head.data;
      rem_q  <= head.last ? head_nbytes : 3'd4;
      last_q <= head.last;
    end else if (state_q == S_BYTE && emit_go) begin
      sr_q   <= sr_q << 8;
      rem_q  <= rem_dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_data_q <= '0;
      asm_cnt_q  <= '0;
    end else if (out_load) begin
      asm_data_q <= '0;
      asm_cnt_q  <= '0;
    end else if (emit_go) begin
      asm_data_q <= asm_ins;
      asm_cnt_q  <= asm_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_nbytes_q <= '0;
      out_last_q   <= 1'b0;
    end else if (out_load) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= flush_go ? asm_data_q : asm_ins;
      out_nbytes_q <= flush_go ? asm_cnt_q : 3'd4;
      out_last_q   <= flush_go;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_nbytes = out_nbytes_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;
  assign busy       = (cnt_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_cb_stream_stuffer.sv
// Bench for cb_stream_stuffer: directed scenarios plus a randomized run scored against a
// byte-stream model of stuffing, padding, EOI insertion and 32-bit repacking.
module tb_cb_stream_stuffer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] in_data = '0, eof_data = '0;
  logic        in_valid = 1'b0, eof = 1'b0, out_ready = 1'b0;
  logic [4:0]  eof_bits = '0;
  logic [31:0] out_data;
  logic        out_valid, out_last, overflow, busy;
  logic [2:0]  out_nbytes;

  cb_stream_stuffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .eof(eof),
    .eof_data(eof_data), .eof_bits(eof_bits), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_nbytes(out_nbytes), .out_last(out_last),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic [2:0] n; logic l; } wrd_t;
  wrd_t       got_q[$];
  wrd_t       exp_q[$];
  logic [7:0] mq[$];
  int n_vec = 0, n_err = 0;

  // words are captured on the falling edge before the rising edge that transfers them
  always @(negedge clk)
    if (rst && out_valid && out_ready) got_q.push_back(wrd_t'({out_data, out_nbytes, out_last}));

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic push_word(input logic [31:0] w);
    in_valid = 1'b1; in_data = w; tick(); in_valid = 1'b0;
  endtask

  task automatic push_eof(input logic [31:0] d, input logic [4:0] b);
    eof = 1'b1; eof_data = d; eof_bits = b; tick(); eof = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, output bit to);
    int c = 0;
    to = 1'b0;
    while (got_q.size() < n) begin
      if (c >= budget) begin to = 1'b1; break; end
      tick(); c++;
    end
  endtask

  function automatic logic [31:0] bmask(input logic [2:0] n);
    return (n >= 3'd4) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> (8 * n));
  endfunction

  // ---------------- reference model ----------------
  function automatic void m_emit(input logic last);
    logic [31:0] d = '0;
    for (int k = 0; k < mq.size(); k++) d[31-8*k -: 8] = mq[k];
    exp_q.push_back(wrd_t'({d, 3'(mq.size()), last}));
    mq.delete();
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    mq.push_back(b);
    if (mq.size() == 4) m_emit(1'b0);
  endfunction

  function automatic void m_data_byte(input logic [7:0] b);
    m_byte(b);
    if (b == 8'hFF) m_byte(8'h00);
  endfunction

  function automatic void m_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) m_data_byte(w[31-8*i -: 8]);
  endfunction

  function automatic void m_eof(input logic [31:0] d, input int bits);
    int nb;
    logic [7:0] b;
    nb = (bits + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      b = d[31-8*i -: 8];
      if (i == nb - 1 && bits % 8 != 0) b = b | 8'((1 << (8 - bits % 8)) - 1);
      m_data_byte(b);
    end
    m_byte(8'hFF);
    mq.push_back(8'hD9);
    m_emit(1'b1);
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[31-8*i -: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    return w;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) tick();
    n_vec++;
    if ({out_valid, out_data, out_nbytes, out_last, overflow, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h n=%0d l=%b ovf=%b busy=%b, required all 0",
               out_valid, out_data, out_nbytes, out_last, overflow, busy);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int seen = 0;
    out_ready = 1'b1;
    push_word(32'h1234_5678);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (out_valid && seen == 0) seen = k;
    end
    n_vec++;
    if (seen != 5) begin
      n_err++; $display("FAIL latency: out_valid after %0d edges, required 5", seen);
    end
    n_vec++;
    if ({out_data, out_nbytes, out_last} !== {32'h1234_5678, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL latency_word: got %h/%0d/%b, required 12345678/4/0", out_data, out_nbytes, out_last);
    end
    repeat (3) tick();
    got_q.delete();
  endtask

  task automatic test_stuffing();
    bit to; wrd_t w;
    push_word(32'hFF00_FF11);
    push_word(32'h2233_4455);
    wait_got(2, 80, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL stuff_timeout: got %0d words, required 2", got_q.size()); end
    else begin
      w = got_q.pop_front(); n_vec++;
      if (w !== wrd_t'({32'hFF00_00FF, 3'd4, 1'b0})) begin
        n_err++; $display("FAIL stuff_w0: got %h/%0d/%b, required ff0000ff/4/0", w.d, w.n, w.l);
      end
      w = got_q.pop_front(); n_vec++;
      if (w !== wrd_t'({32'h0011_2233, 3'd4, 1'b0})) begin
        n_err++; $display("FAIL stuff_w1: got %h/%0d/%b, required 00112233/4/0", w.d, w.n, w.l);
      end
    end
    repeat (10) tick();
    n_vec++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL stuff_hold: got %0d words busy=%b, required 0 words busy=0", got_q.size(), busy);
    end
    push_eof(32'h0, 5'd0);
    wait_got(1, 40, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL stuff_flush_timeout: got 0 words, required 1"); end
    else begin
      w = got_q.pop_front();
      if (w !== wrd_t'({32'h4455_FFD9, 3'd4, 1'b1})) begin
        n_err++; $display("FAIL stuff_flush: got %h/%0d/%b, required 4455ffd9/4/1", w.d, w.n, w.l);
      end
    end
  endtask

  task automatic test_eof();
    bit to; wrd_t w;
    push_eof(32'hABC0_0000, 5'd12);
    wait_got(1, 40, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL eof12_timeout: got 0 words, required 1"); end
    else begin
      w = got_q.pop_front();
      if (w !== wrd_t'({32'hABCF_FFD9, 3'd4, 1'b1})) begin
        n_err++; $display("FAIL eof12: got %h/%0d/%b, required abcfffd9/4/1", w.d, w.n, w.l);
      end
    end
    repeat (3) tick();
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL eof_idle: got busy=%b v=%b, required 0/0", busy, out_valid);
    end
    push_eof(32'hF000_0000, 5'd4);
    wait_got(1, 40, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL eof4_timeout: got 0 words, required 1"); end
    else begin
      w = got_q.pop_front();
      if (w !== wrd_t'({32'hFF00_FFD9, 3'd4, 1'b1})) begin
        n_err++; $display("FAIL eof4_stuffed_pad: got %h/%0d/%b, required ff00ffd9/4/1", w.d, w.n, w.l);
      end
    end
    push_eof(32'h1234_5678, 5'd0);
    wait_got(1, 40, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL eof0_timeout: got 0 words, required 1"); end
    else begin
      w = got_q.pop_front();
      if ((w.d & 32'hFFFF_0000) !== 32'hFFD9_0000 || w.n !== 3'd2 || w.l !== 1'b1) begin
        n_err++; $display("FAIL eof0: got %h/%0d/%b, required ffd9xxxx/2/1", w.d, w.n, w.l);
      end
    end
  endtask

  task automatic test_overflow();
    bit to; wrd_t w;
    logic [31:0] exp_w [DEPTH+2];
    out_ready = 1'b0;
    push_word(32'h0A0B_0C00);
    push_word(32'h0A0B_0C01);
    repeat (20) tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'h0A0B_0C00 || overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_prefill: got v=%b d=%h ovf=%b, required 1/0a0b0c00/0", out_valid, out_data, overflow);
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1; in_data = 32'h0B0C_0D00 | 32'(i);
      tick();
      n_vec++;
      if (overflow !== (i >= DEPTH)) begin
        n_err++; $display("FAIL ovf_flag push %0d: got %b, required %b", i, overflow, (i >= DEPTH));
      end
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 32'h0A0B_0C00) begin
        n_err++; $display("FAIL ovf_stable push %0d: got v=%b d=%h, required 1/0a0b0c00", i, out_valid, out_data);
      end
    end
    in_valid = 1'b0;
    exp_w[0] = 32'h0A0B_0C00;
    exp_w[1] = 32'h0A0B_0C01;
    for (int i = 0; i < DEPTH; i++) exp_w[i+2] = 32'h0B0C_0D00 | 32'(i);
    out_ready = 1'b1;
    wait_got(DEPTH + 2, 300, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL ovf_drain_timeout: got %0d words, required %0d", got_q.size(), DEPTH + 2); end
    else begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        w = got_q.pop_front(); n_vec++;
        if (w !== wrd_t'({exp_w[i], 3'd4, 1'b0})) begin
          n_err++; $display("FAIL ovf_drain[%0d]: got %h/%0d/%b, required %h/4/0", i, w.d, w.n, w.l, exp_w[i]);
        end
      end
    end
    repeat (20) tick();
    n_vec++;
    if (got_q.size() != 0 || busy !== 1'b0 || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_after: got %0d extra words busy=%b ovf=%b, required 0/0/1", got_q.size(), busy, overflow);
    end
    got_q.delete();
  endtask

  task automatic test_same_cycle();
    bit to; wrd_t w;
    in_valid = 1'b1; in_data = 32'h1122_3344;
    eof = 1'b1; eof_data = 32'h5A00_0000; eof_bits = 5'd8;
    tick();
    in_valid = 1'b0; eof = 1'b0;
    wait_got(2, 60, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL same_timeout: got %0d words, required 2", got_q.size()); end
    else begin
      w = got_q.pop_front(); n_vec++;
      if (w !== wrd_t'({32'h1122_3344, 3'd4, 1'b0})) begin
        n_err++; $display("FAIL same_word: got %h/%0d/%b, required 11223344/4/0", w.d, w.n, w.l);
      end
      w = got_q.pop_front(); n_vec++;
      if ((w.d & 32'hFFFF_FF00) !== 32'h5AFF_D900 || w.n !== 3'd3 || w.l !== 1'b1) begin
        n_err++; $display("FAIL same_eof: got %h/%0d/%b, required 5affd9xx/3/1", w.d, w.n, w.l);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to; wrd_t w;
    push_word(32'hAABB_CCDD);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_data, out_nbytes, out_last, overflow, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b d=%h n=%0d l=%b ovf=%b busy=%b, required all 0",
               out_valid, out_data, out_nbytes, out_last, overflow, busy);
    end
    #3 rst = 1'b1;
    tick();
    got_q.delete();
    push_word(32'h0102_0304);
    wait_got(1, 40, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL reset_fresh_timeout: got 0 words, required 1"); end
    else begin
      w = got_q.pop_front();
      if (w !== wrd_t'({32'h0102_0304, 3'd4, 1'b0})) begin
        n_err++; $display("FAIL reset_fresh: got %h/%0d/%b, required 01020304/4/0", w.d, w.n, w.l);
      end
    end
  endtask

  task automatic test_random();
    bit to; wrd_t w, e;
    logic [31:0] d;
    int bits, nexp, gap;
    mq.delete(); exp_q.delete(); got_q.delete();
    for (int ev = 0; ev < 40; ev++) begin
      gap = $urandom_range(10, 16);
      for (int c = 0; c < gap; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      d = rnd_word();
      if (ev == 39 || $urandom_range(0, 4) == 0) begin
        bits = $urandom_range(0, 31);
        push_eof(d, 5'(bits));
        m_eof(d, bits);
      end else begin
        push_word(d);
        m_word(d);
      end
    end
    out_ready = 1'b1;
    nexp = exp_q.size();
    wait_got(nexp, 1000, to);
    n_vec++;
    if (to || got_q.size() != nexp) begin
      n_err++; $display("FAIL rand_count: got %0d words, required %0d", got_q.size(), nexp);
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      w = got_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (w.n !== e.n || w.l !== e.l || ((w.d ^ e.d) & bmask(e.n)) !== 32'h0) begin
        n_err++; $display("FAIL rand_word: got %h/%0d/%b, required %h/%0d/%b", w.d, w.n, w.l, e.d, e.n, e.l);
      end
    end
    repeat (5) tick();
    n_vec++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL rand_end: got busy=%b ovf=%b, required 0/0", busy, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stuffing();
    test_eof();
    test_overflow();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
